// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction/data memory among three requesters.
// The priority order is loader first, then fetch and data reads in round-robin order.
// At most one access is in flight at a time. Every output is a register.
//
// Handshake: a requester raises *_req and holds it. The arbiter samples requests only
// while IDLE. It captures the winner's address (and write data) on that same edge and
// later answers with a one-cycle *_done pulse. The requester must drop *_req no later
// than the cycle after *_done. Dropping it earlier does not cancel the access.
`timescale 1ns/1ps

module imem_arbiter #(
    parameter int unsigned LAT = 1   // mem_en -> mem_rdata latency, 1..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        f_kill,
    output logic        f_done,
    output logic [31:0] f_data,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_done,
    output logic [31:0] d_data,
    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {GNT_F, GNT_D, GNT_L} gnt_t;

    // WAIT counts 0..LAT-1; the edge ending the cycle at LAT-1 captures mem_rdata.
    localparam logic [1:0] LAST_WAIT = 2'(LAT - 1);

    state_t      state_q;
    gnt_t        gnt_q, gnt_d;
    logic        rr_q, rr_d;       // 0: fetch wins the next f/d tie, 1: data wins
    logic        kill_q;           // fetch in flight was redirected
    logic [1:0]  wait_cnt_q;
    logic        any_req;
    logic        mem_en_q, mem_we_q, busy_q;
    logic        f_done_q, d_done_q, l_done_q;
    logic [31:0] mem_addr_q, mem_wdata_q, f_data_q, d_data_q;

    assign any_req = l_req | f_req | d_req;

    // Pick the winner among the current requests. Only a contended f/d tie flips rr.
    always_comb begin
        gnt_d = GNT_D;
        rr_d  = rr_q;
        if (l_req) begin
            gnt_d = GNT_L;
        end else if (f_req && d_req) begin
            gnt_d = rr_q ? GNT_D : GNT_F;
            rr_d  = ~rr_q;
        end else if (f_req) begin
            gnt_d = GNT_F;
        end else begin
            gnt_d = GNT_D;
        end
    end

    // Transaction FSM. It also drives every registered output and the data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_F;
            rr_q        <= 1'b0;
            kill_q      <= 1'b0;
            wait_cnt_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            f_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            l_done_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_data_q    <= '0;
            d_data_q    <= '0;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            f_done_q <= 1'b0;
            d_done_q <= 1'b0;
            l_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q    <= ISSUE;
                        busy_q     <= 1'b1;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= (gnt_d == GNT_L);
                        gnt_q      <= gnt_d;
                        rr_q       <= rr_d;
                        kill_q     <= 1'b0;
                        wait_cnt_q <= '0;
                        case (gnt_d)
                            GNT_L: begin
                                mem_addr_q  <= l_addr;
                                mem_wdata_q <= l_wdata;
                            end
                            GNT_F:   mem_addr_q <= f_addr;
                            default: mem_addr_q <= d_addr;
                        endcase
                    end
                end
                ISSUE: begin
                    if (gnt_q == GNT_L) begin
                        state_q  <= DONE;
                        l_done_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                        if (gnt_q == GNT_F && f_kill) kill_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == LAST_WAIT) begin
                        state_q <= DONE;
                        if (gnt_q == GNT_F) begin
                            // A redirect anywhere in the window (this cycle included) drops the word.
                            if (!kill_q && !f_kill) begin
                                f_data_q <= mem_rdata;
                                f_done_q <= 1'b1;
                            end
                        end else begin
                            d_data_q <= mem_rdata;
                            d_done_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                        if (gnt_q == GNT_F && f_kill) kill_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign f_done    = f_done_q;
    assign f_data    = f_data_q;
    assign d_done    = d_done_q;
    assign d_data    = d_data_q;
    assign l_done    = l_done_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
